wm_phase_timer: RTL

WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

---
 rtl/wm_phase_timer_if.sv | 50 +++++
 rtl/wm_phase_timer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wm_phase_timer_if.sv
// ----------------------------------------------------------------------------
// wm_phase_timer_if
//
// Bundles the signals between the washer controller/sensors and the phase
// timer. The master side is the controller plus the raw tub sensors; the
// slave side is wm_phase_timer.
//
//   tick            : one-cycle time-base pulse from the prescaler
//   motor_on        : motor command
//   fill_valve_on   : fill valve command
//   drain_valve_on  : drain valve command
//   level_raw       : raw tub-full float switch (1 = full)
//   empty_raw       : raw tub-empty switch (1 = empty)
//   prog_cycle_time : wash/rinse duration in ticks
//   prog_spin_time  : spin duration in ticks
//   filled          : debounced level_raw
//   drained         : debounced empty_raw
//   cycle_timeout   : wash/rinse phase expired
//   spin_timeout    : spin phase expired
//   fault           : sticky illegal-command flag
// ----------------------------------------------------------------------------
interface wm_phase_timer_if #(
    parameter int TW = 8
);
    logic          tick;
    logic          motor_on;
    logic          fill_valve_on;
    logic          drain_valve_on;
    logic          level_raw;
    logic          empty_raw;
    logic [TW-1:0] prog_cycle_time;
    logic [TW-1:0] prog_spin_time;
    logic          filled;
    logic          drained;
    logic          cycle_timeout;
    logic          spin_timeout;
    logic          fault;

    modport master (
        output tick, motor_on, fill_valve_on, drain_valve_on,
        output level_raw, empty_raw, prog_cycle_time, prog_spin_time,
        input  filled, drained, cycle_timeout, spin_timeout, fault
    );

    modport slave (
        input  tick, motor_on, fill_valve_on, drain_valve_on,
        input  level_raw, empty_raw, prog_cycle_time, prog_spin_time,
        output filled, drained, cycle_timeout, spin_timeout, fault
    );
endinterface

// File: rtl/wm_phase_timer.sv
// ----------------------------------------------------------------------------
// wm_phase_timer
//
// Washing-machine phase timer. Debounces the tub level/empty switches and
// times the wash/rinse and spin phases against programmed tick counts,
// flagging a sticky fault on illegal valve/motor command combinations.
//
// Parameters:
//   DEB_LEN : consecutive differing samples needed to flip a sensor (1-15)
//   TW      : width of programmed times and the phase counter
//
// Ports:
//   clk   : rising-edge system clock
//   reset : synchronous, active-low reset
//   bus   : wm_phase_timer_if slave modport (commands, sensors, status)
// ----------------------------------------------------------------------------
module wm_phase_timer #(
    parameter int DEB_LEN = 4,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            reset,
    wm_phase_timer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WASH_RUN,
        WASH_DONE,
        SPIN_RUN,
        SPIN_DONE,
        FAULT
    } state_t;

    // The counter toggles the output on the DEB_LEN-th consecutive
    // differing sample, i.e. when it already holds DEB_LEN-1.
    localparam logic [3:0] DEB_LAST = 4'(DEB_LEN - 1);

    logic [3:0]    level_cnt;
    logic [3:0]    empty_cnt;
    logic          filled_q;
    logic          drained_q;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_next;
    logic [TW-1:0] lim;
    logic [TW-1:0] lim_next;

    logic          run_cyc;
    logic          run_spin;
    logic          illegal_cmd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_cnt <= '0;
            filled_q  <= 1'b0;
        end else if (bus.level_raw == filled_q) begin
            level_cnt <= '0;
        end else if (level_cnt == DEB_LAST) begin
            level_cnt <= '0;
            filled_q  <= ~filled_q;
        end else begin
            level_cnt <= level_cnt + 4'd1;
        end
    end

    // The empty switch resets to "drained" so a powered-up empty tub does
    // not have to wait out a debounce window before spin is allowed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            empty_cnt <= '0;
            drained_q <= 1'b1;
        end else if (bus.empty_raw == drained_q) begin
            empty_cnt <= '0;
        end else if (empty_cnt == DEB_LAST) begin
            empty_cnt <= '0;
            drained_q <= ~drained_q;
        end else begin
            empty_cnt <= empty_cnt + 4'd1;
        end
    end

    // run_cyc and run_spin are mutually exclusive because run_cyc needs the
    // drain valve closed and run_spin needs it open.
    assign run_cyc     = bus.motor_on & ~bus.drain_valve_on;
    assign run_spin    = bus.drain_valve_on & drained_q;
    assign illegal_cmd = bus.fill_valve_on & (bus.drain_valve_on | bus.motor_on);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            lim   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lim   <= lim_next;
        end
    end

    // The limit is captured only on entry, so prog_* edits during a run take
    // effect on the next phase. The count stops at lim (the cnt == lim test
    // wins over tick), which keeps it from ever wrapping even at all-ones.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lim_next   = lim;

        unique case (state)
            IDLE: begin
                if (run_cyc) begin
                    state_next = WASH_RUN;
                    cnt_next   = '0;
                    lim_next   = bus.prog_cycle_time;
                end else if (run_spin) begin
                    state_next = SPIN_RUN;
                    cnt_next   = '0;
                    lim_next   = bus.prog_spin_time;
                end
            end
            WASH_RUN: begin
                if (!run_cyc) begin
                    state_next = IDLE;
                end else if (cnt == lim) begin
                    state_next = WASH_DONE;
                end else if (bus.tick) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WASH_DONE: begin
                if (!run_cyc) begin
                    state_next = IDLE;
                end
            end
            SPIN_RUN: begin
                if (!run_spin) begin
                    state_next = IDLE;
                end else if (cnt == lim) begin
                    state_next = SPIN_DONE;
                end else if (bus.tick) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SPIN_DONE: begin
                if (!run_spin) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // An illegal command overrides whatever the phase logic decided.
        if (illegal_cmd) begin
            state_next = FAULT;
        end
    end

    assign bus.filled        = filled_q;
    assign bus.drained       = drained_q;
    assign bus.cycle_timeout = (state == WASH_DONE);
    assign bus.spin_timeout  = (state == SPIN_DONE);
    assign bus.fault         = (state == FAULT);

endmodule
